// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged synchronous FIFO.
// Holds the read-mode type, default thresholds and pointer sizing helpers.
package fifo_pkg;

    typedef enum logic {
        RD_STD  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 64;
    localparam int DEF_AF_MARGIN = 4;
    localparam int DEF_AE_LEVEL  = 4;

    // Address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Ports: clk, we, wr_addr, wr_data, rd_addr, rd_data. Contents are never reset.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and a standard or first-word-fall-through read port.
// Ports: clk, rst (sync, active-high); wr_en/wr_data write side;
// rd_en/rd_data/rd_valid read side; full, empty, almost_full, almost_empty,
// count status; overflow/underflow one-cycle error pulses.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    localparam logic [PW-1:0] ONE   = PW'(1);
    localparam logic [PW-1:0] AF_L  = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L  = PW'(AE_LEVEL);
    localparam logic [PW-1:0] FULLC = PW'(DEPTH);

    localparam rd_mode_e MODE = (FWFT != 0) ? RD_FWFT : RD_STD;

    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be a power of two >= 4");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_flags: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
        $error("sync_fifo_flags: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count_next;
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] ram_q;

    // Acceptance is judged on pre-edge state, so a full FIFO with both
    // requests drains one word and rejects the write, and vice versa.
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    always_comb begin
        count_next = count;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_next = count + ONE;
            2'b01:   count_next = count - ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_LEVEL == 0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ONE;
            end
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == FULLC);
            almost_empty <= (count_next <= AE_L);
            almost_full  <= (count_next >= AF_L);
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

    // The address is shared only when empty or full, where one side is
    // always rejected, so no read-during-write hazard exists.
    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (wr_ok),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (ram_q)
    );

    if (MODE == RD_FWFT) begin : g_fwft
        // Zero while empty so uninitialised storage never reaches the port.
        assign rd_data  = empty ? '0 : ram_q;
        assign rd_valid = ~empty;
    end else begin : g_std
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_ok;
                if (rd_ok) begin
                    rd_data <= ram_q;
                end
            end
        end
    end

    // Pointer distance including the wrap bit must always equal count.
    property p_count_matches_ptrs;
        @(posedge clk) disable iff (rst)
            (wr_ptr - rd_ptr) == count;
    endproperty
    a_count_matches_ptrs: assert property (p_count_matches_ptrs);

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: table vectors, corner sequences,
// and random traffic against a queue-based reference model.
module tb_sync_fifo_flags;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] rd_data;
    logic         rd_valid, full, empty, almost_full, almost_empty;
    logic         overflow, underflow;
    logic [3:0]   count;

    logic         wr_en_b = 1'b0;
    logic         rd_en_b = 1'b0;
    logic [W-1:0] wr_data_b = '0;
    logic [W-1:0] rd_data_b;
    logic         rd_valid_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
    logic [3:0]   count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_flags #(
        .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
    ) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .rd_en(rd_en_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .full(full_b), .empty(empty_b), .almost_full(af_b),
        .almost_empty(ae_b), .count(count_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    // Reference model of the standard-mode instance.
    logic [W-1:0] q[$];
    logic [W-1:0] m_data = '0;
    logic         m_valid = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    typedef struct {
        logic         wr;
        logic         rd;
        logic [W-1:0] din;
        int           cnt;
        logic         ae, af, fl, em, ovf, unf, rv;
        logic [W-1:0] dout;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic w,
                              input logic r_req, input logic [W-1:0] d);
        int n;
        n = q.size();
        if (r) begin
            q.delete();
            m_data = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
        end else begin
            m_ovf   = w && (n == D);
            m_unf   = r_req && (n == 0);
            m_valid = 0;
            if (r_req && n > 0) begin
                m_data  = q.pop_front();
                m_valid = 1;
            end
            if (w && n < D) q.push_back(d);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [W-1:0] d);
        wr_en = w; rd_en = r; wr_data = d;
        @(posedge clk);
        model_step(rst, w, r, d);
        #1;
        wr_en = 0; rd_en = 0;
        wr_en_b = 0; rd_en_b = 0;
    endtask

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == D));
        chk({tag, ".af"}, 32'(almost_full), 32'(n >= AF));
        chk({tag, ".ae"}, 32'(almost_empty), 32'(n <= AE));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
        chk({tag, ".rv"}, 32'(rd_valid), 32'(m_valid));
        chk({tag, ".rdata"}, 32'(rd_data), 32'(m_data));
    endtask

    task automatic do_reset();
        rst = 1;
        step(0, 0, 0);
        rst = 0;
    endtask

    initial begin
        // Fill / overflow / drain / underflow vectors.
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{wr:1, rd:0, din:8'(i + 1), cnt:i + 1,
                       ae:(i + 1 <= 2), af:(i + 1 >= 6), fl:(i == 7),
                       em:0, ovf:0, unf:0, rv:0, dout:8'h00};
        end
        tbl[8] = '{wr:1, rd:0, din:8'h99, cnt:8, ae:0, af:1, fl:1,
                   em:0, ovf:1, unf:0, rv:0, dout:8'h00};
        for (int i = 0; i < 8; i++) begin
            tbl[9 + i] = '{wr:0, rd:1, din:8'h00, cnt:7 - i,
                           ae:(7 - i <= 2), af:(7 - i >= 6), fl:0,
                           em:(i == 7), ovf:0, unf:0, rv:1,
                           dout:8'(i + 1)};
        end
        tbl[17] = '{wr:0, rd:1, din:8'h00, cnt:0, ae:1, af:0, fl:0,
                    em:1, ovf:0, unf:1, rv:0, dout:8'h08};

        // Reset and idle.
        do_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        chk("rst.count", 32'(count), 0);
        chk("rst.empty", 32'(empty), 1);
        chk("rst.ae", 32'(almost_empty), 1);
        chk("rst.full", 32'(full), 0);
        chk("rst.af", 32'(almost_full), 0);
        chk("rst.rv", 32'(rd_valid), 0);
        chk("rst.rdata", 32'(rd_data), 0);
        chk("rst.ovf", 32'(overflow), 0);
        chk("rst.unf", 32'(underflow), 0);
        chk("rst.b_rv", 32'(rd_valid_b), 0);
        chk("rst.b_empty", 32'(empty_b), 1);

        // Table-driven fill and drain.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din);
            chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.ae", i), 32'(almost_empty), 32'(tbl[i].ae));
            chk($sformatf("tbl%0d.af", i), 32'(almost_full), 32'(tbl[i].af));
            chk($sformatf("tbl%0d.full", i), 32'(full), 32'(tbl[i].fl));
            chk($sformatf("tbl%0d.empty", i), 32'(empty), 32'(tbl[i].em));
            chk($sformatf("tbl%0d.ovf", i), 32'(overflow), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d.unf", i), 32'(underflow), 32'(tbl[i].unf));
            chk($sformatf("tbl%0d.rv", i), 32'(rd_valid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d.rdata", i), 32'(rd_data), 32'(tbl[i].dout));
        end

        // Address wrap.
        do_reset();
        for (int i = 0; i < 5; i++) begin step(1, 0, 8'(8'h10 + i)); check_model("wrapw"); end
        for (int i = 0; i < 5; i++) begin step(0, 1, 0); check_model("wrapr"); end
        for (int i = 0; i < 6; i++) begin step(1, 0, 8'(8'hA0 + i)); check_model("wrapw2"); end
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0);
            chk("wrap.rdata", 32'(rd_data), 32'(8'hA0 + i));
            check_model("wrapr2");
        end
        chk("wrap.count", 32'(count), 0);

        // Simultaneous read/write at count=3.
        for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h30 + i));
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 8'(8'h40 + i));
            chk("sim3.count", 32'(count), 3);
            check_model("sim3");
        end
        // Full with both requests.
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h50 + i));
        chk("simf.pre_full", 32'(full), 1);
        step(1, 1, 8'hEE);
        chk("simf.count", 32'(count), 7);
        chk("simf.ovf", 32'(overflow), 1);
        check_model("simf");
        // Empty with both requests.
        for (int i = 0; i < 7; i++) step(0, 1, 0);
        chk("sime.pre_empty", 32'(empty), 1);
        step(1, 1, 8'h5A);
        chk("sime.count", 32'(count), 1);
        chk("sime.unf", 32'(underflow), 1);
        check_model("sime");
        step(0, 1, 0);
        chk("sime.rdata", 32'(rd_data), 32'(8'h5A));

        // FWFT instance.
        do_reset();
        wr_en_b = 1; wr_data_b = 8'h55;
        step(0, 0, 0);
        chk("fwft.rv", 32'(rd_valid_b), 1);
        chk("fwft.rdata", 32'(rd_data_b), 32'(8'h55));
        chk("fwft.count", 32'(count_b), 1);
        step(0, 0, 0);
        chk("fwft.hold", 32'(rd_data_b), 32'(8'h55));
        rd_en_b = 1;
        step(0, 0, 0);
        chk("fwft.rv_off", 32'(rd_valid_b), 0);
        chk("fwft.empty", 32'(empty_b), 1);
        wr_en_b = 1; wr_data_b = 8'h61; step(0, 0, 0);
        wr_en_b = 1; wr_data_b = 8'h62; step(0, 0, 0);
        chk("fwft.head1", 32'(rd_data_b), 32'(8'h61));
        rd_en_b = 1; step(0, 0, 0);
        chk("fwft.head2", 32'(rd_data_b), 32'(8'h62));
        chk("fwft.rv2", 32'(rd_valid_b), 1);
        rd_en_b = 1; step(0, 0, 0);
        rd_en_b = 1; step(0, 0, 0);
        chk("fwft.unf", 32'(unf_b), 1);

        // Reset with count=5 discards contents.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i));
        chk("rst5.pre", 32'(count), 5);
        do_reset();
        chk("rst5.count", 32'(count), 0);
        chk("rst5.empty", 32'(empty), 1);
        chk("rst5.ae", 32'(almost_empty), 1);
        chk("rst5.af", 32'(almost_full), 0);
        chk("rst5.rv", 32'(rd_valid), 0);
        step(1, 0, 8'h77);
        step(0, 1, 0);
        chk("rst5.new", 32'(rd_data), 32'(8'h77));
        chk("rst5.newv", 32'(rd_valid), 1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic w, r;
            int bias;
            bias = (i / 100) % 2 == 0 ? 70 : 30;
            w = ($urandom_range(0, 99) < bias);
            r = ($urandom_range(0, 99) < 100 - bias);
            step(w, r, 8'($urandom));
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
